// File: rtl/bloonstd1_onchip_mem_arbiter.sv
// Round-robin arbiter serialising two Avalon-MM masters onto one single-port RAM (1-cycle read latency).
// Optional per-requester grant counters when BLOONSTD1_MEMARB_STATS_EN is defined.
module bloonstd1_onchip_mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
`ifdef BLOONSTD1_MEMARB_STATS_EN
  ,
  output logic [15:0]         m0_grant_count,
  output logic [15:0]         m1_grant_count
`endif
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                m0_rvld_q, m0_rvld_d;
  logic                m1_rvld_q, m1_rvld_d;

  logic m0_req, m1_req, sel1, issue_live, accept0, accept1;

  assign m0_req     = m0_read | m0_write;
  assign m1_req     = m1_read | m1_write;
  // m1 wins when it is the sole requester, or on a tie when m0 had the last grant
  assign sel1       = m1_req & (~m0_req | ~last_grant_q);
  assign issue_live = (state_q == ISSUE) & ~reset_req;
  assign accept0    = issue_live & ~gnt_q;
  assign accept1    = issue_live & gnt_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_rvld_d    = 1'b0;
    m1_rvld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((m0_req | m1_req) && !reset_req) begin
          gnt_d        = sel1;
          last_grant_d = sel1;
          op_d         = sel1 ? m1_write      : m0_write;
          addr_d       = sel1 ? m1_address    : m0_address;
          be_d         = sel1 ? m1_byteenable : m0_byteenable;
          wdata_d      = sel1 ? m1_writedata  : m0_writedata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!reset_req) state_d = op_q ? IDLE : DATA;
      end
      DATA: begin
        // RAM output is live this cycle; capture is held off while frozen
        if (!reset_req) begin
          if (gnt_q) begin
            m1_rdata_d = mem_readdata;
            m1_rvld_d  = 1'b1;
          end else begin
            m0_rdata_d = mem_readdata;
            m0_rvld_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_rvld_q    <= 1'b0;
      m1_rvld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_rvld_q    <= m0_rvld_d;
      m1_rvld_q    <= m1_rvld_d;
    end
  end

  assign m0_waitrequest   = m0_req & ~accept0;
  assign m1_waitrequest   = m1_req & ~accept1;
  assign m0_readdata      = m0_rdata_q;
  assign m1_readdata      = m1_rdata_q;
  assign m0_readdatavalid = m0_rvld_q;
  assign m1_readdatavalid = m1_rvld_q;

  assign mem_address      = addr_q;
  assign mem_byteenable   = be_q;
  assign mem_writedata    = wdata_q;
  assign mem_chipselect   = issue_live;
  assign mem_write        = issue_live & op_q;
  assign mem_clken        = ~reset_req;

`ifdef BLOONSTD1_MEMARB_STATS_EN
  logic [15:0] m0_cnt_q, m0_cnt_d;
  logic [15:0] m1_cnt_q, m1_cnt_d;

  always_comb begin
    m0_cnt_d = m0_cnt_q;
    m1_cnt_d = m1_cnt_q;
    if (accept0 && (m0_cnt_q != 16'hFFFF)) m0_cnt_d = m0_cnt_q + 16'd1;
    if (accept1 && (m1_cnt_q != 16'hFFFF)) m1_cnt_d = m1_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_cnt_q <= '0;
      m1_cnt_q <= '0;
    end else begin
      m0_cnt_q <= m0_cnt_d;
      m1_cnt_q <= m1_cnt_d;
    end
  end

  assign m0_grant_count = m0_cnt_q;
  assign m1_grant_count = m1_cnt_q;
`endif

endmodule

// File: tb/tb_bloonstd1_onchip_mem_arbiter.sv
// Directed bench for bloonstd1_onchip_mem_arbiter with a behavioural single-port RAM.
module tb_bloonstd1_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [1:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef BLOONSTD1_MEMARB_STATS_EN
  logic [15:0] m0_grant_count, m1_grant_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bloonstd1_onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
`ifdef BLOONSTD1_MEMARB_STATS_EN
    , .m0_grant_count(m0_grant_count), .m1_grant_count(m1_grant_count)
`endif
  );

  // RAM: registered address, combinational output, byte-lane writes
  logic [31:0] ram [4];
  logic [1:0]  ram_areg = 2'd0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      for (int b = 0; b < 4; b++)
        if (mem_write && mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      ram_areg <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_areg];

  typedef struct {
    logic        m0_rd, m0_wr;
    logic [1:0]  m0_a;
    logic [3:0]  m0_be;
    logic [31:0] m0_wd;
    logic        m1_rd, m1_wr;
    logic [1:0]  m1_a;
    logic [3:0]  m1_be;
    logic [31:0] m1_wd;
    logic        e_w0, e_w1, e_v0, e_v1, e_cs, e_mw;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(
    input logic m0rd, m0wr, input logic [1:0] m0a, input logic [3:0] m0be, input logic [31:0] m0wd,
    input logic m1rd, m1wr, input logic [1:0] m1a, input logic [3:0] m1be, input logic [31:0] m1wd,
    input logic w0, w1, v0, v1, cs, mw, input logic [31:0] d0, d1);
    vec_t v;
    v.m0_rd = m0rd; v.m0_wr = m0wr; v.m0_a = m0a; v.m0_be = m0be; v.m0_wd = m0wd;
    v.m1_rd = m1rd; v.m1_wr = m1wr; v.m1_a = m1a; v.m1_be = m1be; v.m1_wd = m1wd;
    v.e_w0 = w0; v.e_w1 = w1; v.e_v0 = v0; v.e_v1 = v1; v.e_cs = cs; v.e_mw = mw;
    v.e_d0 = d0; v.e_d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
  endtask

  initial begin
    // m0 write/read addr 2; m1 full write, byte-lane-1 write, read addr 1
    vt[0]  = mk(0,1,2'd2,4'hF,32'hDEADBEEF, 0,0,0,0,0, 1,0,0,0,0,0, 32'h0,32'h0);
    vt[1]  = mk(0,1,2'd2,4'hF,32'hDEADBEEF, 0,0,0,0,0, 0,0,0,0,1,1, 32'h0,32'h0);
    vt[2]  = mk(1,0,2'd2,4'hF,32'h0,        0,0,0,0,0, 1,0,0,0,0,0, 32'h0,32'h0);
    vt[3]  = mk(1,0,2'd2,4'hF,32'h0,        0,0,0,0,0, 0,0,0,0,1,0, 32'h0,32'h0);
    vt[4]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'h0,32'h0);
    vt[5]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,0, 32'hDEADBEEF,32'h0);
    vt[6]  = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'hDEADBEEF,32'h0);
    vt[7]  = mk(0,0,0,0,0, 0,1,2'd1,4'hF,32'h11223344, 0,1,0,0,0,0, 32'hDEADBEEF,32'h0);
    vt[8]  = mk(0,0,0,0,0, 0,1,2'd1,4'hF,32'h11223344, 0,0,0,0,1,1, 32'hDEADBEEF,32'h0);
    vt[9]  = mk(0,0,0,0,0, 0,1,2'd1,4'h2,32'h0000AB00, 0,1,0,0,0,0, 32'hDEADBEEF,32'h0);
    vt[10] = mk(0,0,0,0,0, 0,1,2'd1,4'h2,32'h0000AB00, 0,0,0,0,1,1, 32'hDEADBEEF,32'h0);
    vt[11] = mk(0,0,0,0,0, 1,0,2'd1,4'hF,32'h0, 0,1,0,0,0,0, 32'hDEADBEEF,32'h0);
    vt[12] = mk(0,0,0,0,0, 1,0,2'd1,4'hF,32'h0, 0,0,0,0,1,0, 32'hDEADBEEF,32'h0);
    vt[13] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'hDEADBEEF,32'h0);
    vt[14] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,0,0, 32'hDEADBEEF,32'h1122AB44);
    vt[15] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'hDEADBEEF,32'h1122AB44);

    reset = 1; reset_req = 0;
    idle_inputs();
    repeat (3) step();
    @(negedge clk);
    chk("rst_cs", 32'(mem_chipselect), 32'h0);
    chk("rst_mw", 32'(mem_write), 32'h0);
    chk("rst_addr", 32'(mem_address), 32'h0);
    chk("rst_clken", 32'(mem_clken), 32'h1);
    chk("rst_v0", 32'(m0_readdatavalid), 32'h0);
    chk("rst_d1", m1_readdata, 32'h0);
    chk("rst_w0", 32'(m0_waitrequest), 32'h0);
    step();
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      m0_read = vt[i].m0_rd; m0_write = vt[i].m0_wr; m0_address = vt[i].m0_a;
      m0_byteenable = vt[i].m0_be; m0_writedata = vt[i].m0_wd;
      m1_read = vt[i].m1_rd; m1_write = vt[i].m1_wr; m1_address = vt[i].m1_a;
      m1_byteenable = vt[i].m1_be; m1_writedata = vt[i].m1_wd;
      @(negedge clk);
      chk($sformatf("v%0d_w0", i), 32'(m0_waitrequest), 32'(vt[i].e_w0));
      chk($sformatf("v%0d_w1", i), 32'(m1_waitrequest), 32'(vt[i].e_w1));
      chk($sformatf("v%0d_v0", i), 32'(m0_readdatavalid), 32'(vt[i].e_v0));
      chk($sformatf("v%0d_v1", i), 32'(m1_readdatavalid), 32'(vt[i].e_v1));
      chk($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vt[i].e_cs));
      chk($sformatf("v%0d_mw", i), 32'(mem_write), 32'(vt[i].e_mw));
      chk($sformatf("v%0d_d0", i), m0_readdata, vt[i].e_d0);
      chk($sformatf("v%0d_d1", i), m1_readdata, vt[i].e_d1);
      step();
    end

    // Both masters hold reads from reset: accepts m0,m1,m0,m1 three cycles apart
    idle_inputs();
    reset = 1;
    m0_read = 1; m0_address = 2'd2; m1_read = 1; m1_address = 2'd1;
    step();
    reset = 0;
    for (int c = 0; c <= 12; c++) begin
      logic held, acc, rv;
      int who, rwho;
      if (c == 11) begin m0_read = 0; m1_read = 0; end
      held = (c < 11);
      acc  = (c % 3 == 1);
      who  = (c / 3) % 2;
      rv   = (c % 3 == 0) && (c > 0);
      rwho = (c >= 3) ? ((c - 3) / 3) % 2 : 0;
      @(negedge clk);
      chk($sformatf("rr%0d_w0", c), 32'(m0_waitrequest), 32'(held && !(acc && who == 0)));
      chk($sformatf("rr%0d_w1", c), 32'(m1_waitrequest), 32'(held && !(acc && who == 1)));
      chk($sformatf("rr%0d_v0", c), 32'(m0_readdatavalid), 32'(rv && rwho == 0));
      chk($sformatf("rr%0d_v1", c), 32'(m1_readdatavalid), 32'(rv && rwho == 1));
      if (rv && rwho == 0) chk($sformatf("rr%0d_d0", c), m0_readdata, 32'hDEADBEEF);
      if (rv && rwho == 1) chk($sformatf("rr%0d_d1", c), m1_readdata, 32'h1122AB44);
      step();
    end

    // reset_req held for 5 cycles while the read sits in DATA
    m0_read = 1; m0_address = 2'd2;
    @(negedge clk); chk("rq0_w0", 32'(m0_waitrequest), 32'h1); step();
    @(negedge clk); chk("rq1_w0", 32'(m0_waitrequest), 32'h0); step();
    m0_read = 0; m1_read = 1; m1_address = 2'd1; reset_req = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rq_frz%0d_clken", k), 32'(mem_clken), 32'h0);
      chk($sformatf("rq_frz%0d_cs", k), 32'(mem_chipselect), 32'h0);
      chk($sformatf("rq_frz%0d_v0", k), 32'(m0_readdatavalid), 32'h0);
      chk($sformatf("rq_frz%0d_w1", k), 32'(m1_waitrequest), 32'h1);
      step();
    end
    reset_req = 0;
    @(negedge clk);
    chk("rq7_clken", 32'(mem_clken), 32'h1);
    chk("rq7_v0", 32'(m0_readdatavalid), 32'h0);
    chk("rq7_w1", 32'(m1_waitrequest), 32'h1);
    step();
    @(negedge clk);
    chk("rq8_v0", 32'(m0_readdatavalid), 32'h1);
    chk("rq8_d0", m0_readdata, 32'hDEADBEEF);
    chk("rq8_w1", 32'(m1_waitrequest), 32'h1);
    step();
    @(negedge clk); chk("rq9_w1", 32'(m1_waitrequest), 32'h0); step();
    m1_read = 0;
    @(negedge clk); chk("rq10_v1", 32'(m1_readdatavalid), 32'h0); step();
    @(negedge clk);
    chk("rq11_v1", 32'(m1_readdatavalid), 32'h1);
    chk("rq11_d1", m1_readdata, 32'h1122AB44);
    step();

    // reset pulsed while an m0 read is in ISSUE
    m0_read = 1; m0_address = 2'd2;
    @(negedge clk); chk("rs0_w0", 32'(m0_waitrequest), 32'h1); step();
    @(negedge clk);
    chk("rs1_w0", 32'(m0_waitrequest), 32'h0);
    chk("rs1_cs", 32'(mem_chipselect), 32'h1);
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("rs2_cs", 32'(mem_chipselect), 32'h0);
    chk("rs2_v0", 32'(m0_readdatavalid), 32'h0);
    chk("rs2_d0", m0_readdata, 32'h0);
    chk("rs2_addr", 32'(mem_address), 32'h0);
    chk("rs2_w0", 32'(m0_waitrequest), 32'h1);
    step();
    @(negedge clk);
    chk("rs3_w0", 32'(m0_waitrequest), 32'h0);
    chk("rs3_v0", 32'(m0_readdatavalid), 32'h0);
    step();
    m0_read = 0;
    @(negedge clk); chk("rs4_v0", 32'(m0_readdatavalid), 32'h0); step();
    @(negedge clk);
    chk("rs5_v0", 32'(m0_readdatavalid), 32'h1);
    chk("rs5_d0", m0_readdata, 32'hDEADBEEF);
    step();

`ifdef BLOONSTD1_MEMARB_STATS_EN
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("st_rst_c0", 32'(m0_grant_count), 32'h0);
    chk("st_rst_c1", 32'(m1_grant_count), 32'h0);
    m0_write = 1; m0_address = 2'd0; m0_byteenable = 4'hF; m0_writedata = 32'h1;
    m1_write = 1; m1_address = 2'd0; m1_byteenable = 4'hF; m1_writedata = 32'h2;
    step();
    for (int c = 0; c < 10; c++) begin
      if (c == 8) m1_write = 0;
      step();
    end
    m0_write = 0;
    @(negedge clk);
    chk("st_c0", 32'(m0_grant_count), 32'h3);
    chk("st_c1", 32'(m1_grant_count), 32'h2);
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("st_clr_c0", 32'(m0_grant_count), 32'h0);
    chk("st_clr_c1", 32'(m1_grant_count), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
